// File: rtl/bird_pkg.sv
// Shared types and default constants for the bird column controller.
package bird_pkg;

   typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;

   localparam int ROWS      = 16;
   localparam int FALL_DIV  = 4;
   localparam int FLAP_ROWS = 2;
   localparam int START_ROW = 8;

endpackage

// File: rtl/step_timer.sv
// Step-slot timer: counts 0..DIV-1 while enabled; slot is high in the cycle
// the counter sits at its terminal value, so the wrap edge is the step edge.
module step_timer #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic RST,
   input  logic en,
   input  logic force_slot,
   input  logic clear,
   output logic slot
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] TERM = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge RST) begin
      if (RST)             cnt <= '0;
      else if (clear)      cnt <= '0;
      else if (force_slot) cnt <= TERM;
      else if (en)         cnt <= (cnt == TERM) ? '0 : cnt + CW'(1);
   end

   assign slot = en && (cnt == TERM);

endmodule

// File: rtl/bird_ctrl.sv
// Bird motion and life-cycle controller: key flaps and gravity steps become
// one-cycle up/down strobes; ground and pipe hits end the run.
module bird_ctrl #(
   parameter int ROWS      = bird_pkg::ROWS,
   parameter int FALL_DIV  = bird_pkg::FALL_DIV,
   parameter int FLAP_ROWS = bird_pkg::FLAP_ROWS,
   parameter int START_ROW = bird_pkg::START_ROW
) (
   input  logic                    clk,
   input  logic                    RST,
   input  logic                    key,
   input  logic [ROWS-1:0]         pipe,
   output logic                    up,
   output logic                    down,
   output logic                    dead,
   output logic [$clog2(ROWS)-1:0] row,
   output logic                    playing
);

   import bird_pkg::*;

   localparam int RW = $clog2(ROWS);
   localparam logic [RW-1:0] TOP   = RW'(ROWS - 1);
   localparam logic [RW-1:0] START = RW'(START_ROW);
   localparam logic [RW-1:0] FLAP  = RW'(FLAP_ROWS);

   state_t        state;
   logic          key_q;
   logic [RW-1:0] pending;
   logic          rise, slot, in_play, hit, force_slot, clear;

   assign rise    = key & ~key_q;
   assign in_play = (state == PLAY);
   assign hit     = in_play && pipe[row];
   // A press landing on a slot uses that slot as its first up-step, so the
   // counter is only forced when no slot is being taken this cycle.
   assign force_slot = rise && ((state == IDLE) || (in_play && !slot && !hit));
   assign clear      = rise && (state == DEAD);

   step_timer #(.DIV(FALL_DIV)) u_timer (
      .clk        (clk),
      .RST        (RST),
      .en         (in_play),
      .force_slot (force_slot),
      .clear      (clear),
      .slot       (slot)
   );

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         row     <= START;
         pending <= '0;
         key_q   <= 1'b0;
         up      <= 1'b0;
         down    <= 1'b0;
         dead    <= 1'b0;
         playing <= 1'b0;
      end else begin
         key_q <= key;
         up    <= 1'b0;
         down  <= 1'b0;
         case (state)
            IDLE: begin
               row <= START;
               if (rise) begin
                  state   <= PLAY;
                  pending <= FLAP;
                  playing <= 1'b1;
               end
            end
            PLAY: begin
               if (hit) begin
                  state   <= DEAD;
                  dead    <= 1'b1;
                  playing <= 1'b0;
               end else if (slot) begin
                  if (rise || pending != '0) begin
                     if (row == TOP) begin
                        pending <= '0;
                     end else begin
                        up      <= 1'b1;
                        row     <= row + RW'(1);
                        pending <= rise ? FLAP - RW'(1) : pending - RW'(1);
                     end
                  end else if (row == '0) begin
                     state   <= DEAD;
                     dead    <= 1'b1;
                     playing <= 1'b0;
                  end else begin
                     down <= 1'b1;
                     row  <= row - RW'(1);
                  end
               end else if (rise) begin
                  pending <= FLAP;
               end
            end
            DEAD: begin
               if (rise) begin
                  state   <= IDLE;
                  row     <= START;
                  pending <= '0;
                  dead    <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bird_ctrl.sv
// Directed bench for bird_ctrl at default parameters.
module tb_bird_ctrl;

   logic        clk;
   logic        RST;
   logic        key;
   logic [15:0] pipe;
   logic        up, down, dead, playing;
   logic [3:0]  row;

   int          n_chk, n_fail;
   logic [7:0]  exp;
   logic [7:0]  obs;

   bird_ctrl dut (
      .clk     (clk),
      .RST     (RST),
      .key     (key),
      .pipe    (pipe),
      .up      (up),
      .down    (down),
      .dead    (dead),
      .row     (row),
      .playing (playing)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign obs = {up, down, dead, playing, row};

   // flags = {up, down, dead, playing}
   function automatic logic [7:0] st(input logic [3:0] f, input logic [3:0] r);
      return {f, r};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press();
      key = 1'b1;
      tick();
      key = 1'b0;
   endtask

   task automatic run_n(input int n, output int ups, output int downs);
      ups   = 0;
      downs = 0;
      repeat (n) begin
         tick();
         ups   += int'(up);
         downs += int'(down);
      end
   endtask

   task automatic test_reset();
      int u, d;
      repeat (3) tick();
      exp = st(4'b0000, 4'd8); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL reset_hold: got %b want %b", obs, exp); end
      RST = 1'b0;
      press();
      tick();
      exp = st(4'b1001, 4'd9); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL pre_reset_up: got %b want %b", obs, exp); end
      #2 RST = 1'b1;
      #1;
      exp = st(4'b0000, 4'd8); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL async_reset: got %b want %b", obs, exp); end
      #2 RST = 1'b0;
      run_n(20, u, d);
      n_chk++;
      if (u + d != 0) begin n_fail++; $display("FAIL idle_strobes: got %0d want 0", u + d); end
      exp = st(4'b0000, 4'd8); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL idle_state: got %b want %b", obs, exp); end
   endtask

   task automatic test_start_fall();
      int u, d;
      press();
      exp = st(4'b0001, 4'd8); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL start_play: got %b want %b", obs, exp); end
      tick();
      exp = st(4'b1001, 4'd9); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL flap1: got %b want %b", obs, exp); end
      run_n(3, u, d);
      n_chk++;
      if (u + d != 0) begin n_fail++; $display("FAIL flap_gap: got %0d strobes want 0", u + d); end
      tick();
      exp = st(4'b1001, 4'd10); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL flap2: got %b want %b", obs, exp); end
      run_n(3, u, d);
      n_chk++;
      if (u + d != 0) begin n_fail++; $display("FAIL fall_gap: got %0d strobes want 0", u + d); end
      tick();
      exp = st(4'b0101, 4'd9); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL fall1: got %b want %b", obs, exp); end
      run_n(3, u, d);
      tick();
      exp = st(4'b0101, 4'd8); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL fall2: got %b want %b", obs, exp); end
   endtask

   task automatic test_ground();
      int u, d;
      for (int r = 7; r >= 0; r--) begin
         run_n(3, u, d);
         tick();
         exp = st(4'b0101, 4'(r)); n_chk++;
         if (obs !== exp) begin n_fail++; $display("FAIL ground_fall r=%0d: got %b want %b", r, obs, exp); end
      end
      run_n(3, u, d);
      tick();
      exp = st(4'b0010, 4'd0); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL ground_dead: got %b want %b", obs, exp); end
      run_n(8, u, d);
      exp = st(4'b0010, 4'd0); n_chk++;
      if (obs !== exp || u + d != 0) begin
         n_fail++; $display("FAIL dead_frozen: got %b strobes %0d want %b strobes 0", obs, u + d, exp);
      end
      press();
      exp = st(4'b0000, 4'd8); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL dead_to_idle: got %b want %b", obs, exp); end
   endtask

   task automatic test_top();
      int u, d, tu, td;
      tick();
      tu = 0;
      td = 0;
      for (int c = 0; c < 3; c++) begin
         press();
         run_n(7, u, d);
         tu += u;
         td += d;
      end
      exp = st(4'b0001, 4'd14); n_chk++;
      if (obs !== exp || tu != 6 || td != 0) begin
         n_fail++; $display("FAIL climb: got %b ups %0d downs %0d want %b ups 6 downs 0", obs, tu, td, exp);
      end
      press();
      tick();
      exp = st(4'b1001, 4'd15); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL reach_top: got %b want %b", obs, exp); end
      run_n(3, u, d);
      tick();
      exp = st(4'b0001, 4'd15); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL top_clip: got %b want %b", obs, exp); end
      run_n(2, u, d);
      press();
      tick();
      exp = st(4'b0001, 4'd15); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL top_press: got %b want %b", obs, exp); end
      run_n(3, u, d);
      tick();
      exp = st(4'b0101, 4'd14); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL top_fall: got %b want %b", obs, exp); end
   endtask

   task automatic test_collision();
      int u, d;
      for (int r = 13; r >= 7; r--) begin
         run_n(3, u, d);
         tick();
         exp = st(4'b0101, 4'(r)); n_chk++;
         if (obs !== exp) begin n_fail++; $display("FAIL coll_fall r=%0d: got %b want %b", r, obs, exp); end
      end
      run_n(3, u, d);
      pipe = 16'h0080;
      tick();
      pipe = 16'h0000;
      exp = st(4'b0010, 4'd7); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL collision: got %b want %b", obs, exp); end
      press();
      exp = st(4'b0000, 4'd8); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL coll_to_idle: got %b want %b", obs, exp); end
   endtask

   task automatic test_hold_and_reset();
      int u, d;
      tick();
      key = 1'b1;
      run_n(30, u, d);
      key = 1'b0;
      n_chk++;
      if (u != 2 || d != 6) begin n_fail++; $display("FAIL hold_count: got ups %0d downs %0d want ups 2 downs 6", u, d); end
      exp = st(4'b0101, 4'd4); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL hold_state: got %b want %b", obs, exp); end
      #2 RST = 1'b1;
      #1;
      exp = st(4'b0000, 4'd8); n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL midrun_reset: got %b want %b", obs, exp); end
      tick();
      RST = 1'b0;
      run_n(6, u, d);
      exp = st(4'b0000, 4'd8); n_chk++;
      if (obs !== exp || u + d != 0) begin
         n_fail++; $display("FAIL post_reset_idle: got %b strobes %0d want %b strobes 0", obs, u + d, exp);
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      RST    = 1'b1;
      key    = 1'b0;
      pipe   = 16'h0000;
      test_reset();
      test_start_fall();
      test_ground();
      test_top();
      test_collision();
      test_hold_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
